// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gcd_pkg
// Brief    : Shared types and constants for the subtractive GCD controller.
// Revision : 1.0
// ============================================================================
package gcd_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_SUB_A = 3'd2,
      ST_SUB_B = 3'd3,
      ST_DONE  = 3'd4
   } gcd_state_e;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : Small combinational ALU (pass, OR, subtract) shared by the GCD FSM.
// Revision : 1.0
// ============================================================================
module alu
   import gcd_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       op_i,
   output logic [WIDTH-1:0] y_o
);

   always_comb begin
      y_o = a_i;
      case (op_i)
         ALU_PASS: y_o = a_i;
         ALU_OR:   y_o = a_i | b_i;
         ALU_SUB:  y_o = a_i - b_i;
         default:  y_o = a_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/gcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gcd_ctrl
// Brief    : Subtractive GCD controller; all arithmetic goes through one ALU.
// Revision : 1.0
// ============================================================================
module gcd_ctrl
   import gcd_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   gcd_state_e       state_q;
   logic [WIDTH-1:0] ra_q;
   logic [WIDTH-1:0] rb_q;
   logic [WIDTH-1:0] result_q;
   logic             err_q;
   logic             done_q;
   logic             busy_q;

   logic [WIDTH-1:0] w_alu_a;
   logic [WIDTH-1:0] w_alu_b;
   logic [2:0]       w_alu_op;
   logic [WIDTH-1:0] w_alu_y;
   logic             w_any_zero;
   logic             w_both_zero;
   logic             w_equal;
   logic             w_a_gt_b;

   assign w_any_zero  = (ra_q == '0) || (rb_q == '0);
   assign w_both_zero = (ra_q == '0) && (rb_q == '0);
   assign w_equal     = (ra_q == rb_q);
   assign w_a_gt_b    = (ra_q > rb_q);

   // Operand muxes swap only for SUB_B; PASS is the idle opcode.
   always_comb begin
      w_alu_a  = ra_q;
      w_alu_b  = rb_q;
      w_alu_op = ALU_PASS;
      case (state_q)
         ST_CHECK: if (w_any_zero) w_alu_op = ALU_OR;
         ST_SUB_A: w_alu_op = ALU_SUB;
         ST_SUB_B: begin
            w_alu_a  = rb_q;
            w_alu_b  = ra_q;
            w_alu_op = ALU_SUB;
         end
         default:  w_alu_op = ALU_PASS;
      endcase
   end

   alu #(.WIDTH(WIDTH)) u_alu (
      .a_i  (w_alu_a),
      .b_i  (w_alu_b),
      .op_i (w_alu_op),
      .y_o  (w_alu_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ra_q     <= '0;
         rb_q     <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  ra_q    <= a_in;
                  rb_q    <= b_in;
                  busy_q  <= 1'b1;
                  state_q <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (w_any_zero) begin
                  result_q <= w_alu_y;
                  err_q    <= w_both_zero;
                  done_q   <= 1'b1;
                  state_q  <= ST_DONE;
               end else if (w_equal) begin
                  result_q <= w_alu_y;
                  err_q    <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= ST_DONE;
               end else if (w_a_gt_b) begin
                  state_q  <= ST_SUB_A;
               end else begin
                  state_q  <= ST_SUB_B;
               end
            end
            ST_SUB_A: begin
               ra_q    <= w_alu_y;
               state_q <= ST_CHECK;
            end
            ST_SUB_B: begin
               rb_q    <= w_alu_y;
               state_q <= ST_CHECK;
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_ctrl
// Brief    : Self-checking bench for gcd_ctrl against an arithmetic GCD model.
// Revision : 1.0
// ============================================================================
module tb_gcd_ctrl;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a_in  = '0;
   logic [W-1:0] b_in  = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gcd_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a_in   (a_in),
      .b_in   (b_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .err    (err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int gcd_ref(input int a, input int b);
      int x = a;
      int y = b;
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // Number of subtractions the subtractive algorithm needs before a stop condition.
   function automatic int sub_count(input int a, input int b);
      int x = a;
      int y = b;
      int k = 0;
      while (x != 0 && y != 0 && x != y) begin
         if (x > y) x = x - y;
         else       y = y - x;
         k++;
      end
      return k;
   endfunction

   // noise: 0 = quiet inputs, 1 = random start/operands while busy, 2 = start with (9,6) while busy
   task automatic run_gcd(input logic [W-1:0] a, input logic [W-1:0] b, input int noise);
      int exp_res;
      int exp_cyc;
      int c;
      bit seen;
      exp_res = gcd_ref(int'(a), int'(b));
      exp_cyc = 2 * sub_count(int'(a), int'(b)) + 2;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(posedge clk);
      c    = 0;
      seen = 1'b0;
      while (!seen && c < 600) begin
         @(negedge clk);
         c++;
         case (noise)
            1: begin
               start = 1'($urandom_range(0, 1));
               a_in  = W'($urandom);
               b_in  = W'($urandom);
            end
            2: begin
               start = 1'b1;
               a_in  = 8'd9;
               b_in  = 8'd6;
            end
            default: start = 1'b0;
         endcase
         if (done) begin
            seen = 1'b1;
            start = 1'b0;
            chk("done_cycle", c, exp_cyc);
            chk("result", result, exp_res);
            chk("err", err, (a == 0 && b == 0) ? 1 : 0);
            chk("busy_done", busy, 1);
         end else begin
            chk("busy_run", busy, 1);
         end
      end
      chk("done_seen", seen, 1);
   endtask

   initial begin
      int ra;
      int rb;
      bit early_done;

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;

      run_gcd(8'd12, 8'd8, 0);
      run_gcd(8'd12, 8'd8, 2);
      run_gcd(8'd9, 8'd6, 0);
      run_gcd(8'd255, 8'd1, 0);
      run_gcd(8'd1, 8'd255, 1);
      run_gcd(8'd7, 8'd7, 0);
      run_gcd(8'd0, 8'd9, 0);
      run_gcd(8'd9, 8'd0, 1);
      run_gcd(8'd0, 8'd0, 0);
      run_gcd(8'd200, 8'd150, 1);

      for (int i = 0; i < 25; i++) begin
         ra = int'($urandom_range(0, 255));
         rb = int'($urandom_range(0, 255));
         if (i % 7 == 3) rb = ra;
         if (i % 9 == 4) ra = 0;
         run_gcd(W'(ra), W'(rb), 1);
      end

      // Abort a long computation with an asynchronous reset mid-flight.
      run_gcd(8'd9, 8'd6, 0);
      @(negedge clk);
      a_in  = 8'd255;
      b_in  = 8'd1;
      start = 1'b1;
      @(posedge clk);
      early_done = 1'b0;
      for (int c = 1; c < 100; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) early_done = 1'b1;
      end
      chk("abort_no_early_done", early_done, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_result", result, 0);
      chk("abort_err", err, 0);
      repeat (3) begin
         @(negedge clk);
         chk("abort_hold_done", done, 0);
         chk("abort_hold_busy", busy, 0);
      end
      rst_n = 1'b1;
      run_gcd(8'd21, 8'd14, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gcd_ctrl.md
GCD_CTRL -- requirements
Module: gcd_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port `clk`: input, 1 bit, system clock; all state changes on the rising edge.
REQ-003 Port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-004 Port `start`: input, 1 bit, request to compute a GCD; sampled only in IDLE.
REQ-005 Port `a_in`: input, 8 bits, operand A; captured with `start`.
REQ-006 Port `b_in`: input, 8 bits, operand B; captured with `start`.
REQ-007 Port `busy`: output, 1 bit, high whenever state is not IDLE.
REQ-008 Port `done`: output, 1 bit, one-cycle pulse while in DONE.
REQ-009 Port `result`: output, 8 bits, registered GCD; holds its value until the next completion.
REQ-010 Port `err`: output, 1 bit, registered; set at completion iff both operands were 0; holds until the next completion.
REQ-011 Parameter `WIDTH`: default 8, datapath width; every operand, internal register and `result` is `WIDTH` bits.

Function
REQ-012 FSM states SHALL be IDLE, CHECK, SUB_A, SUB_B and DONE.
REQ-013 IDLE transition: with `start`=1, capture ra<=`a_in` and rb<=`b_in`, then go to CHECK; with `start`=0, stay in IDLE.
REQ-014 CHECK, first match applies:
- ra==0 or rb==0: result<=ALU OR(ra,rb); err<=(ra==0 && rb==0); go to DONE.
- ra==rb: result<=ALU PASS(ra); err<=0; go to DONE.
- ra>rb: go to SUB_A.
- otherwise: go to SUB_B.
REQ-015 SUB_A: ra<=ALU SUB(A=ra, B=rb); go to CHECK.
REQ-016 SUB_B: rb<=ALU SUB(A=rb, B=ra); go to CHECK.
REQ-017 DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-018 All arithmetic SHALL go through the single ALU instance. Comparisons (==0, ==, >) are unsigned `WIDTH`-bit compares in the controller. SUB never underflows by construction.
REQ-019 Latency: with `start` accepted in cycle 0 and k subtractions, `done` is high in cycle 2k+2 exactly.
REQ-020 Worst-case latency for WIDTH=8 is (255,1): k=254, so `done` is high in cycle 510.
REQ-021 `start` SHALL be ignored while `busy`=1, including in DONE; the earliest next acceptance is the cycle after DONE.
REQ-022 `a_in`/`b_in` changes after capture SHALL NOT affect the computation in progress.
REQ-023 When the ALU is unused (IDLE, DONE), its opcode SHALL be PASS, so the combinational output is deterministic.

Reset
REQ-024 While `rst_n`=0: state=IDLE; ra, rb, `result`=0; `err`, `done`, `busy`=0.
REQ-025 Reset asserted mid-computation SHALL abort it: no `done` pulse, `result` cleared, and the first `start` after release is accepted normally.

Structure
REQ-026 Package `gcd_pkg` SHALL hold:
- the FSM state enum typedef;
- ALU opcode localparams ALU_PASS=3'b000, ALU_OR=3'b010, ALU_SUB=3'b101;
- default WIDTH=8.
REQ-027 Exactly one sub-module, the existing `alu`, SHALL be instantiated. `gcd_ctrl` drives its A/B operand muxes and its 3-bit opcode.

Verification
REQ-028 (12,8), `start` in cycle 0 -> `done` in cycle 6, `result`=4, `err`=0, `busy` high in cycles 1-6.
REQ-029 (255,1) -> `done` in cycle 510, `result`=1. (7,7) -> `done` in cycle 2, `result`=7.
REQ-030 (0,9) -> `done` in cycle 2, `result`=9, `err`=0. (0,0) -> `done` in cycle 2, `result`=0, `err`=1.
REQ-031 (12,8) started, then `start` with (9,6) in cycles 2-6 -> ignored, `result`=4. (9,6) started in cycle 7 -> `done` in cycle 13, `result`=3.
REQ-032 (255,1) started, `rst_n` low in cycle 100 -> outputs 0 immediately (asynchronous), no `done`. After release, (21,14) -> `result`=7.
